// File: rtl/coco_kbd_matrix_seq.sv
// coco_kbd_matrix_seq: PS/2 key events are queued in a FIFO, resolved through an
// external scancode ROM and applied to a ROWS x COLS key matrix. A sequencer holds
// each new key state for MIN_HOLD cycles and wraps remapped keys in a virtual SHIFT
// with SETTLE cycles of separation.
// Optional build macro: KBD_GHOST_EN (passive-matrix ghosting on the row returns).
module coco_kbd_matrix_seq #(
  parameter int ROWS       = 7,
  parameter int COLS       = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_HOLD   = 50000,
  parameter int SETTLE     = 1000,
  parameter int SHIFT_ROW  = 6,
  parameter int SHIFT_COL  = 7
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [10:0]             ps2_key,
  output logic [8:0]              lk_code,
  input  logic                    lk_valid,
  input  logic [$clog2(ROWS)-1:0] lk_row,
  input  logic [$clog2(COLS)-1:0] lk_col,
  input  logic                    lk_shift,
  input  logic [COLS-1:0]         col_sel,
  input  logic [ROWS-1:0]         ext_low,
  output logic [ROWS-1:0]         rows,
  output logic                    busy,
  output logic                    overflow
);

  localparam int RW          = $clog2(ROWS);
  localparam int CW          = $clog2(COLS);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int TMAX        = (MIN_HOLD > SETTLE) ? MIN_HOLD : SETTLE;
  localparam int TW          = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam int HOLD_LAST   = (MIN_HOLD > 0) ? MIN_HOLD - 1 : 0;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int VW          = 8;

  typedef enum logic [2:0] {IDLE, SH_WAIT, KEY_SET, SH_REL, HOLD} state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [VW-1:0]        vshift_cnt;
  logic                 ev_press;
  logic                 ev_shift;
  logic [RW-1:0]        ev_row;
  logic [CW-1:0]        ev_col;
  logic [ROWS*COLS-1:0] key_q;
  logic [ROWS*COLS-1:0] key_eff;
  logic [COLS-1:0]      col_drv;
  logic [ROWS-1:0]      rows_nxt;
  logic [ROWS-1:0]      rows_q;

  logic                 tog_q;
  logic                 armed;
  logic [9:0]           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fifo_cnt;
  logic [9:0]           head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 push_ok;
  logic                 pop;
  logic                 overflow_q;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign push       = armed && (ps2_key[10] != tog_q);
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts alongside a pop.
  assign push_ok    = push && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr];
  assign lk_code    = fifo_empty ? 9'd0 : head[8:0];
  assign busy       = !fifo_empty || (state != IDLE);
  assign rows       = rows_q;
  assign overflow   = overflow_q;

  // Event capture: toggle detection, FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q      <= 1'b0;
      armed      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      tog_q <= ps2_key[10];
      armed <= 1'b1;
      if (pop)            rd_ptr     <= rd_ptr + AW'(1);
      if (push_ok)        wr_ptr     <= wr_ptr + AW'(1);
      if (push && !push_ok) overflow_q <= 1'b1;
      fifo_cnt <= fifo_cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // FIFO storage: {pressed, extended, scancode}; contents are don't-care while empty.
  always_ff @(posedge clk_sys) begin
    if (push_ok) fifo_mem[wr_ptr] <= ps2_key[9:0];
  end

  // Sequencer: pop, optional shift settle, key write, shift release settle, hold.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      vshift_cnt <= '0;
      ev_press   <= 1'b0;
      ev_shift   <= 1'b0;
      ev_row     <= '0;
      ev_col     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            ev_press <= head[9];
            ev_shift <= lk_shift;
            ev_row   <= lk_row;
            ev_col   <= lk_col;
            timer    <= '0;
            if (lk_valid) begin
              if (head[9] && lk_shift) begin
                if (vshift_cnt != '1) vshift_cnt <= vshift_cnt + VW'(1);
                state <= (vshift_cnt == '0) ? SH_WAIT : KEY_SET;
              end else begin
                state <= KEY_SET;
              end
            end
          end
        end
        SH_WAIT: begin
          if (timer == TW'(SETTLE_LAST)) begin
            timer <= '0;
            state <= KEY_SET;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        KEY_SET: begin
          timer <= '0;
          // The last shifted key to lift keeps SHIFT down through SH_REL, so the
          // CPU sees the key go up before the virtual SHIFT does.
          if (!ev_press && ev_shift) begin
            if (vshift_cnt <= VW'(1)) begin
              state <= SH_REL;
            end else begin
              vshift_cnt <= vshift_cnt - VW'(1);
              state      <= HOLD;
            end
          end else begin
            state <= HOLD;
          end
        end
        SH_REL: begin
          if (timer == TW'(SETTLE_LAST)) begin
            vshift_cnt <= '0;
            timer      <= '0;
            state      <= HOLD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLD: begin
          if (timer == TW'(HOLD_LAST)) state <= IDLE;
          else                         timer <= timer + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Key matrix: the latched event's bit is written during KEY_SET.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q <= '0;
    end else if (state == KEY_SET) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (ev_row == RW'(r) && ev_col == CW'(c)) key_q[r*COLS + c] <= ev_press;
    end
  end

  // Effective matrix: virtual shift ORs onto the real SHIFT position.
  always_comb begin
    key_eff = key_q;
    if (vshift_cnt != '0) key_eff[SHIFT_ROW*COLS + SHIFT_COL] = 1'b1;
  end

  // Row returns before the output register; ghosting adds one level of column coupling.
  always_comb begin
    col_drv = ~col_sel;
`ifdef KBD_GHOST_EN
    for (int r = 0; r < ROWS; r++)
      if (|(key_eff[r*COLS +: COLS] & ~col_sel)) col_drv = col_drv | key_eff[r*COLS +: COLS];
`endif
    rows_nxt = '1;
    for (int r = 0; r < ROWS; r++)
      rows_nxt[r] = ~(ext_low[r] | (|(key_eff[r*COLS +: COLS] & col_drv)));
  end

  // Output register for the active-low row returns.
  always_ff @(posedge clk_sys) begin
    if (reset) rows_q <= '1;
    else       rows_q <= rows_nxt;
  end

endmodule

// File: tb/tb_coco_kbd_matrix_seq.sv
// Bench for coco_kbd_matrix_seq: directed scenarios with hand-computed literals plus
// randomized traffic, all checked every cycle against an event-timeline model.
module tb_coco_kbd_matrix_seq;

  localparam int ROWS = 7, COLS = 8, DEPTH = 4, MIN_HOLD = 20, SETTLE = 5;
  localparam int SHIFT_ROW = 6, SHIFT_COL = 7;
  localparam int H = MIN_HOLD, S = SETTLE;

  logic            clk_sys;
  logic            reset;
  logic [10:0]     ps2_key;
  logic [8:0]      lk_code;
  logic            lk_valid;
  logic [2:0]      lk_row;
  logic [2:0]      lk_col;
  logic            lk_shift;
  logic [COLS-1:0] col_sel;
  logic [ROWS-1:0] ext_low;
  logic [ROWS-1:0] rows;
  logic            busy;
  logic            overflow;

  int vectors = 0;
  int miscompares = 0;

  coco_kbd_matrix_seq #(
    .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH), .MIN_HOLD(MIN_HOLD), .SETTLE(SETTLE),
    .SHIFT_ROW(SHIFT_ROW), .SHIFT_COL(SHIFT_COL)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .lk_code(lk_code),
    .lk_valid(lk_valid), .lk_row(lk_row), .lk_col(lk_col), .lk_shift(lk_shift),
    .col_sel(col_sel), .ext_low(ext_low), .rows(rows), .busy(busy), .overflow(overflow)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Scancode ROM: scan[5:3]=row (7 unmapped), scan[2:0]=col, scan[7]=unmapped, extended=needs shift.
  function automatic bit rom_valid(input logic [8:0] code);
    return !code[7] && (code[5:3] != 3'd7);
  endfunction

  always_comb begin
    lk_valid = rom_valid(lk_code);
    lk_row   = lk_code[5:3];
    lk_col   = lk_code[2:0];
    lk_shift = lk_code[8];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: event timeline ----------------
  bit          mk [ROWS][COLS];
  int          vc;
  logic [9:0]  mq[$];
  bit          m_armed;
  logic        m_tog;
  bit          m_ovf;
  longint      cyc;
  longint      next_pop;
  bit          pk_en;
  longint      pk_edge;
  bit          pk_val;
  int          pk_r, pk_c;
  bit          pd_en;
  longint      pd_edge;
  int          pd_val;
  logic [ROWS-1:0] exp_rows;

  function automatic logic [ROWS-1:0] model_rows(input logic [COLS-1:0] cs, input logic [ROWS-1:0] el);
    logic [ROWS-1:0] res;
    bit hit, k;
    for (int r = 0; r < ROWS; r++) begin
      hit = el[r];
      for (int c = 0; c < COLS; c++) begin
        k = mk[r][c] || (r == SHIFT_ROW && c == SHIFT_COL && vc > 0);
        if (k && !cs[c]) hit = 1'b1;
      end
      res[r] = !hit;
    end
    return res;
  endfunction

  // Work out when this event's effects land and when the next event may start.
  task automatic schedule(input logic [9:0] ev, input longint e);
    logic [8:0] code;
    longint k;
    int was;
    code = ev[8:0];
    if (!rom_valid(code)) begin
      next_pop = e + 1;
      return;
    end
    pk_r = int'(code[5:3]);
    pk_c = int'(code[2:0]);
    if (ev[9]) begin
      if (code[8]) begin
        was = vc;
        vc  = vc + 1;
        k   = (was == 0) ? e + S + 1 : e + 1;
      end else begin
        k = e + 1;
      end
      pk_en = 1; pk_edge = k; pk_val = 1;
      next_pop = k + 1 + H;
    end else begin
      k = e + 1;
      pk_en = 1; pk_edge = k; pk_val = 0;
      if (code[8]) begin
        if (vc <= 1) begin
          pd_en = 1; pd_edge = k + S; pd_val = 0;
          next_pop = k + 1 + S + H;
        end else begin
          pd_en = 1; pd_edge = k; pd_val = vc - 1;
          next_pop = k + 1 + H;
        end
      end else begin
        next_pop = k + 1 + H;
      end
    end
  endtask

  initial begin : model
    logic [9:0] ev;
    logic [8:0] exp_code;
    bit exp_busy;
    cyc = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      cyc++;
      if (reset === 1'b1) begin
        foreach (mk[r, c]) mk[r][c] = 0;
        vc = 0; mq.delete(); m_armed = 0; m_ovf = 0;
        pk_en = 0; pd_en = 0; next_pop = cyc + 1;
        exp_rows = '1;
      end else begin
        exp_rows = model_rows(col_sel, ext_low);
        if (cyc >= next_pop && mq.size() > 0) begin
          ev = mq.pop_front();
          schedule(ev, cyc);
        end
        if (!m_armed) begin
          m_armed = 1;
          m_tog = ps2_key[10];
        end else if (ps2_key[10] !== m_tog) begin
          m_tog = ps2_key[10];
          if (mq.size() < DEPTH) mq.push_back(ps2_key[9:0]);
          else m_ovf = 1;
        end
        if (pk_en && pk_edge == cyc) begin
          mk[pk_r][pk_c] = pk_val;
          pk_en = 0;
        end
        if (pd_en && pd_edge == cyc) begin
          vc = pd_val;
          pd_en = 0;
        end
      end
      exp_code = (mq.size() > 0) ? mq[0][8:0] : 9'd0;
      exp_busy = (mq.size() > 0) || (next_pop > cyc + 1);
      chk("rows", rows, exp_rows);
      chk("lk_code", lk_code, exp_code);
      chk("busy", busy, exp_busy);
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit pr, input logic [8:0] code);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    chk("idle_within_budget", (busy === 1'b0), 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int low, t4, t6, r4, r6, gap;
    logic [8:0] codes [8];
    codes = '{9'h001, 9'h126, 9'h115, 9'h03F, 9'h080, 9'h037, 9'h12A, 9'h00B};
    reset   = 1'b1;
    ps2_key = '0;
    col_sel = '1;
    ext_low = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_rows", rows, 7'h7F);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_lk_code", lk_code, 0);

    // Tap 'A' (row 0, col 1): low for hold + key-set + release latency = MIN_HOLD+2.
    col_sel = 8'hFD;
    send(1, 9'h001);
    low = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_sys);
      if (i == 3) ps2_key = {~ps2_key[10], 1'b0, 9'h001};
      if (rows[0] === 1'b0) low++;
    end
    chk("tap_low_cycles", low, 22);
    wait_idle(100);
    chk("tap_released", rows[0], 1);

    // Shifted key (row 4, col 6): shift leads by SETTLE+1 on press, trails by SETTLE on release.
    col_sel = 8'h3F;
    send(1, 9'h126);
    t4 = -1; t6 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      if (t6 < 0 && rows[6] === 1'b0) t6 = i;
      if (t4 < 0 && rows[4] === 1'b0) t4 = i;
    end
    chk("shift_press_lead", t4 - t6, 6);
    wait_idle(100);
    send(0, 9'h126);
    r4 = -1; r6 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      if (r4 < 0 && rows[4] === 1'b1) r4 = i;
      if (r6 < 0 && rows[6] === 1'b1) r6 = i;
    end
    chk("shift_release_lag", r6 - r4, 5);
    wait_idle(100);

    // Overlapping shifted keys: one settle in, one settle out; shift low 77 cycles.
    col_sel = 8'h7F;
    send(1, 9'h126);
    low = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_sys);
      if (i == 1) ps2_key = {~ps2_key[10], 1'b1, 9'h115};
      if (i == 2) ps2_key = {~ps2_key[10], 1'b0, 9'h126};
      if (i == 3) ps2_key = {~ps2_key[10], 1'b0, 9'h115};
      if (rows[6] === 1'b0) low++;
    end
    chk("overlap_shift_low", low, 77);
    wait_idle(100);

    // Overflow: sequencer busy, then DEPTH+1 back-to-back events; the last is dropped.
    col_sel = '1;
    send(1, 9'h001);
    tick(2);
    send(1, 9'h002);
    send(1, 9'h003);
    send(1, 9'h004);
    send(1, 9'h005);
    send(1, 9'h00A);
    tick(1);
    chk("overflow_set", overflow, 1);
    wait_idle(400);
    col_sel = 8'hFB;
    tick(2);
    chk("dropped_not_applied", rows[1], 1);
    chk("queued_applied", rows[0], 0);

    // Reset in the middle of a shift settle.
    col_sel = 8'h7F;
    send(1, 9'h126);
    tick(3);
    do_reset();
    chk("midreset_rows", rows, 7'h7F);
    chk("midreset_busy", busy, 0);
    chk("midreset_overflow", overflow, 0);

    // External row force, then an unmapped event.
    col_sel = '1;
    ext_low = 7'h01;
    tick(2);
    chk("ext_low_row0", rows, 7'h7E);
    ext_low = '0;
    col_sel = 8'hFE;
    tick(2);
    send(1, 9'h080);
    @(negedge clk_sys);
    chk("unmapped_queued_busy", busy, 1);
    @(negedge clk_sys);
    chk("unmapped_back_idle", busy, 0);
    chk("unmapped_no_key", rows, 7'h7F);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 30);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk_sys);
        col_sel = 8'($urandom);
        ext_low = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
      end
      send(1'($urandom), codes[$urandom_range(0, 7)]);
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    wait_idle(3000);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
